// File: rtl/multiplicador_seq_if.sv
// Operand/result bundle for the sequential 8x8 multiplier.
// The slave side (the multiplier) consumes A/B and publishes c/contador.
interface multiplicador_seq_if;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] c;
    logic [2:0]  contador;

    modport master (
        output A,
        output B,
        input  c,
        input  contador
    );

    modport slave (
        input  A,
        input  B,
        output c,
        output contador
    );
endinterface

// File: rtl/multiplicador_seq.sv
// Free-running 8x8 unsigned shift-and-add multiplier, one product every 8 cycles.
// Latency 8 edges from operand sample (contador==0) to c; no backpressure, A/B ignored outside phase 0.
module multiplicador_seq (
    input  logic                clk,
    input  logic                rst,
    multiplicador_seq_if.slave  bus
);

    logic [7:0]  a_reg_q, a_reg_d;
    logic [7:0]  b_reg_q, b_reg_d;
    logic [15:0] acc_q, acc_d;
    logic [2:0]  contador_q, contador_d;
    logic [15:0] c_q, c_d;
    logic [15:0] pp;

    always_comb begin
        a_reg_d    = a_reg_q;
        b_reg_d    = b_reg_q;
        acc_d      = acc_q;
        c_d        = c_q;
        contador_d = contador_q + 3'd1;
        pp         = '0;

        if (contador_q == 3'd0) begin
            // Bit 0 comes straight from the live inputs so no phase is wasted on loading.
            a_reg_d = bus.A;
            b_reg_d = bus.B;
            acc_d   = bus.B[0] ? {8'h00, bus.A} : 16'h0000;
        end else begin
            if (b_reg_q[contador_q]) begin
                pp = {8'h00, a_reg_q} << contador_q;
            end
            acc_d = acc_q + pp;
            if (contador_q == 3'd7) begin
                c_d = acc_q + pp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg_q    <= '0;
            b_reg_q    <= '0;
            acc_q      <= '0;
            contador_q <= '0;
            c_q        <= '0;
        end else begin
            a_reg_q    <= a_reg_d;
            b_reg_q    <= b_reg_d;
            acc_q      <= acc_d;
            contador_q <= contador_d;
            c_q        <= c_d;
        end
    end

    assign bus.c        = c_q;
    assign bus.contador = contador_q;

endmodule

// File: tb/tb_multiplicador_seq.sv
// Bench for multiplicador_seq: arithmetic product model checked every cycle plus directed literal checks.
module tb_multiplicador_seq;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    bit   chk_en;

    multiplicador_seq_if bus ();

    multiplicador_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: a product A*B sampled at phase 0 appears on c after 8 edges.
    int          m_phase;
    logic [15:0] m_pending;
    logic [15:0] m_c;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_c     = 16'h0000;
        end else begin
            if (m_phase == 0) m_pending = 16'(bus.A) * 16'(bus.B);
            if (m_phase == 7) m_c = m_pending;
            m_phase = (m_phase + 1) % 8;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if (bus.c !== m_c) begin
                bad++;
                $display("FAIL model_c t=%0t got=%h want=%h", $time, bus.c, m_c);
            end
            total++;
            if (bus.contador !== 3'(m_phase)) begin
                bad++;
                $display("FAIL model_contador t=%0t got=%0d want=%0d", $time, bus.contador, m_phase);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        chk_en = 1'b0;
        rst    = 1'b1;
        bus.A  = 8'h12;
        bus.B  = 8'h34;

        // Reset held for two edges
        step(1);
        chk_en = 1'b1;
        chk("rst1_c", bus.c, 16'h0000);
        chk("rst1_cnt", 16'(bus.contador), 16'd0);
        step(1);
        chk("rst2_c", bus.c, 16'h0000);
        chk("rst2_cnt", 16'(bus.contador), 16'd0);

        // 3*5
        rst   = 1'b0;
        bus.A = 8'd3;
        bus.B = 8'd5;
        step(1);
        chk("basic_cnt1", 16'(bus.contador), 16'd1);
        step(6);
        chk("basic_cnt7", 16'(bus.contador), 16'd7);
        chk("basic_c_before", bus.c, 16'h0000);
        step(1);
        chk("basic_c", bus.c, 16'h000F);
        chk("basic_cnt_wrap", 16'(bus.contador), 16'd0);

        // Extremes
        bus.A = 8'd255;
        bus.B = 8'd255;
        step(8);
        chk("max_c", bus.c, 16'hFE01);
        bus.A = 8'd0;
        bus.B = 8'd200;
        step(8);
        chk("zero_c", bus.c, 16'h0000);
        bus.A = 8'd200;
        bus.B = 8'd1;
        step(8);
        chk("b1_c", bus.c, 16'd200);

        // Operand change mid-window is ignored until the next phase 0
        bus.A = 8'd10;
        bus.B = 8'd10;
        step(3);
        bus.A = 8'd7;
        bus.B = 8'd9;
        step(5);
        chk("iso_c100", bus.c, 16'd100);
        step(8);
        chk("iso_c63", bus.c, 16'd63);

        // Hold: c stays put while inputs toggle every cycle
        bus.A = 8'h0F;
        bus.B = 8'h11;
        step(1);
        chk("hold_c0", bus.c, 16'd63);
        for (int i = 0; i < 6; i++) begin
            bus.A = 8'($urandom_range(0, 255));
            bus.B = 8'($urandom_range(0, 255));
            step(1);
            chk("hold_c", bus.c, 16'd63);
        end
        step(1);
        chk("hold_new_c", bus.c, 16'd255);

        // Reset in the middle of a window
        bus.A = 8'h80;
        bus.B = 8'h80;
        step(4);
        chk("mid_cnt4", 16'(bus.contador), 16'd4);
        rst = 1'b1;
        step(1);
        chk("mid_rst_c", bus.c, 16'h0000);
        chk("mid_rst_cnt", 16'(bus.contador), 16'd0);
        rst = 1'b0;
        step(8);
        chk("mid_after_c", bus.c, 16'h4000);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
